// File: rtl/memory_turn_ctrl_if.sv
// rtl/memory_turn_ctrl_if.sv - bus bundle between turn controller and game datapath/inputs
//
// Purpose: groups the key/switch inputs, datapath verdicts and the controller's
// outputs so the controller takes a single bus port.
// Ports (signals):
//   start, next_card, match, deck_empty      : driven by master (inputs/datapath)
//   next_card_output, output_correct_answer,
//   analyse, card_idx, lives_left, streak,
//   best_streak, game_over, win, state       : driven by slave (turn controller)
interface memory_turn_ctrl_if #(
  parameter int CIDX_W   = 1,
  parameter int LIVES_W  = 2,
  parameter int STREAK_W = 8
);
  logic                start;
  logic                next_card;
  logic                match;
  logic                deck_empty;
  logic                next_card_output;
  logic                output_correct_answer;
  logic                analyse;
  logic [CIDX_W-1:0]   card_idx;
  logic [LIVES_W-1:0]  lives_left;
  logic [STREAK_W-1:0] streak;
  logic [STREAK_W-1:0] best_streak;
  logic                game_over;
  logic                win;
  logic [2:0]          state;

  modport master (
    output start, next_card, match, deck_empty,
    input  next_card_output, output_correct_answer, analyse, card_idx,
           lives_left, streak, best_streak, game_over, win, state
  );

  modport slave (
    input  start, next_card, match, deck_empty,
    output next_card_output, output_correct_answer, analyse, card_idx,
           lives_left, streak, best_streak, game_over, win, state
  );
endinterface

// File: rtl/memory_turn_ctrl.sv
// rtl/memory_turn_ctrl.sv - parametrised turn controller for the memory card game
//
// Purpose: sequences CARDS_PER_TURN card reveals per turn, strobes analyse for
// one cycle, scores the match verdict (lives, streak, best streak) and ends the
// game on loss of all lives or deck exhaustion.
// Ports:
//   clk    : single clock, rising edge
//   resetn : synchronous active-low reset
//   bus    : memory_turn_ctrl_if slave modport (inputs start/next_card/match/
//            deck_empty; outputs strobes, card_idx, lives_left, streak,
//            best_streak, game_over, win, state)
module memory_turn_ctrl #(
  parameter int CARDS_PER_TURN = 2,
  parameter int CHAIN          = 1,
  parameter int LIVES          = 3,
  parameter int STREAK_W       = 8,
  parameter int FINISH_CYCLES  = 4
) (
  input logic               clk,
  input logic               resetn,
  memory_turn_ctrl_if.slave bus
);

  localparam int CIDX_W  = (CARDS_PER_TURN <= 2) ? 1 : $clog2(CARDS_PER_TURN);
  localparam int LIVES_W = $clog2(LIVES + 1);
  localparam int FCNT_W  = (FINISH_CYCLES <= 2) ? 1 : $clog2(FINISH_CYCLES);

  localparam logic [CIDX_W-1:0]  LAST_IDX  = CIDX_W'(CARDS_PER_TURN - 1);
  localparam logic [CIDX_W-1:0]  CHAIN_IDX = CIDX_W'((CHAIN != 0) ? 1 : 0);
  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(LIVES);
  localparam logic [FCNT_W-1:0]  FCNT_LAST  = FCNT_W'(FINISH_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CARD    = 3'd1,
    S_ANALYZE = 3'd2,
    S_RIGHT   = 3'd3,
    S_WRONG   = 3'd4,
    S_FINISH  = 3'd5
  } state_t;

  state_t              state_q;
  logic [CIDX_W-1:0]   idx_q;
  logic [LIVES_W-1:0]  lives_q;
  logic [STREAK_W-1:0] streak_q;
  logic [STREAK_W-1:0] best_q;
  logic                win_q;
  logic [FCNT_W-1:0]   fcnt_q;

  // Saturating increment; the same value feeds streak and the best-streak max.
  logic [STREAK_W-1:0] streak_inc;
  assign streak_inc = (&streak_q) ? streak_q : streak_q + STREAK_W'(1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      lives_q  <= LIVES_INIT;
      streak_q <= '0;
      best_q   <= '0;
      win_q    <= 1'b0;
      fcnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q  <= S_CARD;
            idx_q    <= '0;
            lives_q  <= LIVES_INIT;
            streak_q <= '0;
            win_q    <= 1'b0;
          end
        end
        S_CARD: begin
          // No edge detection: every high cycle of next_card advances a card.
          if (bus.next_card) begin
            if (idx_q == LAST_IDX) state_q <= S_ANALYZE;
            else                   idx_q   <= idx_q + CIDX_W'(1);
          end
        end
        S_ANALYZE: begin
          state_q <= bus.match ? S_RIGHT : S_WRONG;
        end
        S_RIGHT: begin
          streak_q <= streak_inc;
          if (streak_inc > best_q) best_q <= streak_inc;
          if (bus.deck_empty) begin
            state_q <= S_FINISH;
            win_q   <= 1'b1;
            fcnt_q  <= '0;
          end else begin
            state_q <= S_CARD;
            // With chaining the last card shown becomes card 0 of the next turn.
            idx_q   <= CHAIN_IDX;
          end
        end
        S_WRONG: begin
          streak_q <= '0;
          lives_q  <= lives_q - LIVES_W'(1);
          // Losing the last life beats deck exhaustion.
          if (lives_q == LIVES_W'(1)) begin
            state_q <= S_FINISH;
            win_q   <= 1'b0;
            fcnt_q  <= '0;
          end else if (bus.deck_empty) begin
            state_q <= S_FINISH;
            win_q   <= 1'b1;
            fcnt_q  <= '0;
          end else begin
            state_q <= S_CARD;
            idx_q   <= '0;
          end
        end
        S_FINISH: begin
          if (fcnt_q == FCNT_LAST) state_q <= S_IDLE;
          else                     fcnt_q  <= fcnt_q + FCNT_W'(1);
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Moore strobes decoded from registered state and card index.
  assign bus.next_card_output      = (state_q == S_CARD);
  assign bus.output_correct_answer = (state_q == S_CARD) && (idx_q != '0);
  assign bus.analyse               = (state_q == S_ANALYZE);
  assign bus.game_over             = (state_q == S_FINISH);
  assign bus.card_idx              = idx_q;
  assign bus.lives_left            = lives_q;
  assign bus.streak                = streak_q;
  assign bus.best_streak           = best_q;
  assign bus.win                   = win_q;
  assign bus.state                 = state_q;

endmodule

// File: tb/tb_memory_turn_ctrl.sv
// tb/tb_memory_turn_ctrl.sv - self-checking bench for memory_turn_ctrl
module tb_memory_turn_ctrl;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  memory_turn_ctrl_if #(.CIDX_W(1), .LIVES_W(2), .STREAK_W(8)) ifa ();
  memory_turn_ctrl_if #(.CIDX_W(2), .LIVES_W(2), .STREAK_W(2)) ifb ();

  memory_turn_ctrl dut_a (.clk(clk), .resetn(resetn), .bus(ifa));

  memory_turn_ctrl #(
    .CARDS_PER_TURN(3), .CHAIN(0), .LIVES(2), .STREAK_W(2), .FINISH_CYCLES(3)
  ) dut_b (.clk(clk), .resetn(resetn), .bus(ifb));

  int n_tests = 0;
  int n_fail  = 0;

  bit sel = 1'b0;
  logic [2:0] o_state;
  logic [7:0] o_idx, o_lives, o_streak, o_best;
  logic       o_nco, o_oca, o_an, o_go, o_win;

  always_comb begin
    if (sel) begin
      o_state = ifb.state; o_idx = 8'(ifb.card_idx); o_lives = 8'(ifb.lives_left);
      o_streak = 8'(ifb.streak); o_best = 8'(ifb.best_streak);
      o_nco = ifb.next_card_output; o_oca = ifb.output_correct_answer;
      o_an = ifb.analyse; o_go = ifb.game_over; o_win = ifb.win;
    end else begin
      o_state = ifa.state; o_idx = 8'(ifa.card_idx); o_lives = 8'(ifa.lives_left);
      o_streak = 8'(ifa.streak); o_best = 8'(ifa.best_streak);
      o_nco = ifa.next_card_output; o_oca = ifa.output_correct_answer;
      o_an = ifa.analyse; o_go = ifa.game_over; o_win = ifa.win;
    end
  end

  // Reference model: game-level bookkeeping from the rules of play.
  int m_idx, m_lives, m_streak, m_best, m_win;
  int m_cpt, m_chain, m_lmax, m_smax, m_fin;
  bit m_done;
  int bests[2] = '{0, 0};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic set_in(input logic st, input logic nc, input logic mt, input logic de);
    if (sel) begin
      ifb.start = st; ifb.next_card = nc; ifb.match = mt; ifb.deck_empty = de;
    end else begin
      ifa.start = st; ifa.next_card = nc; ifa.match = mt; ifa.deck_empty = de;
    end
  endtask

  task automatic select_dut(input bit s);
    bests[sel] = m_best;
    sel = s;
    m_best = bests[s];
    if (!s) begin m_cpt = 2; m_chain = 1; m_lmax = 3; m_smax = 255; m_fin = 4; end
    else    begin m_cpt = 3; m_chain = 0; m_lmax = 2; m_smax = 3;   m_fin = 3; end
    #1;
  endtask

  task automatic start_game();
    logic [35:0] got, exp;
    set_in(1'b1, rb(), rb(), rb());
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    m_idx = 0; m_lives = m_lmax; m_streak = 0; m_win = 0;
    got = {o_state, o_nco, o_idx, o_lives, o_streak, o_best, o_win};
    exp = {3'd1, 1'b1, 8'd0, 8'(m_lives), 8'd0, 8'(m_best), 1'b0};
    if (got !== exp) begin n_fail++; $display("FAIL start_game: got %0h want %0h", got, exp); end
    n_tests++;
  endtask

  // Plays one turn from a CARD cycle; m = verdict, de = deck_empty at the verdict exit.
  task automatic play_turn(input bit m, input bit de);
    int guard;
    bit nc, fin;
    logic [14:0] g15, e15;
    logic [23:0] g24, e24;
    logic [28:0] g29, e29;
    guard = 0;
    forever begin
      g15 = {o_state, o_nco, o_oca, o_an, o_idx};
      e15 = {3'd1, 1'b1, 1'(m_idx != 0), 1'b0, 8'(m_idx)};
      if (g15 !== e15) begin n_fail++; $display("FAIL card_cycle: got %0h want %0h", g15, e15); end
      n_tests++;
      nc = ($urandom_range(0, 2) != 0) || (guard > 6);
      set_in(rb(), nc, rb(), rb());
      @(negedge clk);
      guard++;
      if (nc) begin
        if (m_idx == m_cpt - 1) break;
        m_idx++;
      end
    end
    g15 = {9'd0, o_state, o_an, o_nco, o_oca};
    e15 = {9'd0, 3'd2, 1'b1, 1'b0, 1'b0};
    if (g15 !== e15) begin n_fail++; $display("FAIL analyze: got %0h want %0h", g15, e15); end
    n_tests++;
    set_in(rb(), rb(), m, rb());
    @(negedge clk);
    g15 = {10'd0, o_state, o_an, o_go};
    e15 = {10'd0, (m ? 3'd3 : 3'd4), 1'b0, 1'b0};
    if (g15 !== e15) begin n_fail++; $display("FAIL verdict_state: got %0h want %0h", g15, e15); end
    n_tests++;
    set_in(rb(), rb(), rb(), de);
    @(negedge clk);
    fin = 1'b0;
    if (m) begin
      m_streak = (m_streak + 1 > m_smax) ? m_smax : m_streak + 1;
      if (m_streak > m_best) m_best = m_streak;
      if (de) begin fin = 1'b1; m_win = 1; end
      else m_idx = m_chain;
    end else begin
      m_streak = 0;
      m_lives--;
      if (m_lives == 0) begin fin = 1'b1; m_win = 0; end
      else if (de) begin fin = 1'b1; m_win = 1; end
      else m_idx = 0;
    end
    g24 = {o_lives, o_streak, o_best};
    e24 = {8'(m_lives), 8'(m_streak), 8'(m_best)};
    if (g24 !== e24) begin n_fail++; $display("FAIL score: got %0h want %0h", g24, e24); end
    n_tests++;
    if (!fin) begin
      g15 = {3'd0, o_state, o_nco, o_idx};
      e15 = {3'd0, 3'd1, 1'b1, 8'(m_idx)};
      if (g15 !== e15) begin n_fail++; $display("FAIL next_turn: got %0h want %0h", g15, e15); end
      n_tests++;
    end else begin
      for (int i = 0; i < m_fin; i++) begin
        g15 = {10'd0, o_state, o_go, o_win};
        e15 = {10'd0, 3'd5, 1'b1, 1'(m_win)};
        if (g15 !== e15) begin n_fail++; $display("FAIL finish_cycle%0d: got %0h want %0h", i, g15, e15); end
        n_tests++;
        set_in(1'b1, rb(), rb(), rb());
        @(negedge clk);
      end
      g29 = {o_state, o_go, o_win, o_lives, o_streak, o_best};
      e29 = {3'd0, 1'b0, 1'(m_win), 8'(m_lives), 8'(m_streak), 8'(m_best)};
      if (g29 !== e29) begin n_fail++; $display("FAIL finish_exit: got %0h want %0h", g29, e29); end
      n_tests++;
      set_in(1'b0, 1'b0, 1'b0, 1'b0);
    end
    m_done = fin;
  endtask

  task automatic test_reset();
    logic [31:0] got, exp;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (int s = 0; s < 2; s++) begin
      select_dut(1'(s));
      m_best = 0;
      got = {o_state, o_lives, o_streak, o_best, o_win, o_nco, o_oca, o_an, o_go};
      exp = {3'd0, 8'(m_lmax), 8'd0, 8'd0, 5'd0};
      if (got !== exp) begin n_fail++; $display("FAIL reset_dut%0d: got %0h want %0h", s, got, exp); end
      n_tests++;
    end
    @(negedge clk);
  endtask

  task automatic test_chained_turn();
    select_dut(1'b0);
    start_game();
    play_turn(1'b1, 1'b0);
    if ({o_streak, o_best} !== {8'd1, 8'd1}) begin
      n_fail++; $display("FAIL chain_streak: got %0h want 0101", {o_streak, o_best});
    end
    n_tests++;
    if ({o_state, o_idx, o_oca} !== {3'd1, 8'd1, 1'b1}) begin
      n_fail++; $display("FAIL chain_idx: got %0h want %0h", {o_state, o_idx, o_oca}, {3'd1, 8'd1, 1'b1});
    end
    n_tests++;
  endtask

  task automatic test_loss();
    for (int t = 0; t < 3; t++) play_turn(1'b0, 1'b0);
    if ({o_state, o_lives, o_win, o_go} !== {3'd0, 8'd0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL loss: got %0h want 0", {o_state, o_lives, o_win, o_go});
    end
    n_tests++;
  endtask

  task automatic test_random_games();
    repeat (3) begin
      start_game();
      m_done = 1'b0;
      for (int t = 0; t < 30 && !m_done; t++)
        play_turn($urandom_range(0, 3) != 0, (t == 29) || ($urandom_range(0, 9) == 0));
    end
  endtask

  task automatic test_three_card();
    select_dut(1'b1);
    start_game();
    play_turn(1'b1, 1'b0);
    if ({o_state, o_idx, o_oca} !== {3'd1, 8'd0, 1'b0}) begin
      n_fail++; $display("FAIL three_card_nochain: got %0h want %0h", {o_state, o_idx, o_oca}, {3'd1, 8'd0, 1'b0});
    end
    n_tests++;
  endtask

  task automatic test_saturation();
    repeat (3) play_turn(1'b1, 1'b0);
    play_turn(1'b1, 1'b1);
    if ({o_streak, o_best, o_win} !== {8'd3, 8'd3, 1'b1}) begin
      n_fail++; $display("FAIL saturate: got %0h want %0h", {o_streak, o_best, o_win}, {8'd3, 8'd3, 1'b1});
    end
    n_tests++;
    start_game();
    if ({o_streak, o_best} !== {8'd0, 8'd3}) begin
      n_fail++; $display("FAIL restart_keeps_best: got %0h want 0003", {o_streak, o_best});
    end
    n_tests++;
    play_turn(1'b1, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic [31:0] got, exp;
    select_dut(1'b0);
    start_game();
    for (int i = 0; i < m_cpt; i++) begin
      set_in(1'b0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
    end
    if ({o_state, o_an} !== {3'd2, 1'b1}) begin
      n_fail++; $display("FAIL mid_reach_analyze: got %0h want 5", {o_state, o_an});
    end
    n_tests++;
    resetn = 1'b0;
    set_in(1'b1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0, 1'b0);
    m_best = 0; bests[1] = 0;
    got = {o_state, o_lives, o_streak, o_best, o_win, o_nco, o_oca, o_an, o_go};
    exp = {3'd0, 8'd3, 8'd0, 8'd0, 5'd0};
    if (got !== exp) begin n_fail++; $display("FAIL reset_mid: got %0h want %0h", got, exp); end
    n_tests++;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    ifa.start = 1'b0; ifa.next_card = 1'b0; ifa.match = 1'b0; ifa.deck_empty = 1'b0;
    ifb.start = 1'b0; ifb.next_card = 1'b0; ifb.match = 1'b0; ifb.deck_empty = 1'b0;
    m_best = 0;
    select_dut(1'b0);
    test_reset();
    test_chained_turn();
    test_loss();
    test_random_games();
    test_three_card();
    test_saturation();
    test_random_games();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
